// File: rtl/atm_txn_sequencer.sv
// Front-end sequencer for the ATM core: queues requests, replays each one on the
// ATM ports with a reset pulse and fixed hold window, then returns the captured result.
module atm_txn_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_acc_num,
  input  logic [2:0]  in_operation,
  input  logic [13:0] in_pin,
  input  logic [13:0] in_new_pin,
  input  logic [15:0] in_amount,
  input  logic        in_language,
  output logic        atm_rst,
  output logic [2:0]  atm_operation,
  output logic [3:0]  atm_acc_num,
  output logic [13:0] atm_pin,
  output logic [13:0] atm_new_pin,
  output logic [15:0] atm_amount,
  output logic        atm_language,
  input  logic [31:0] atm_balance,
  input  logic        atm_success,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_balance,
  output logic        res_success,
  output logic [3:0]  res_acc_num,
  output logic [7:0]  res_seq,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int EW = 52;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESTART = 3'd1,
    S_HOLD    = 3'd2,
    S_CAPTURE = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic [EW-1:0]   r_cmd;
  logic [EW-1:0]   w_entry;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_cnt_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_capture;
  logic            w_done;
  logic            w_atm_rst_nxt;
  logic            w_res_valid_nxt;
  logic            w_busy_nxt;
  logic            w_in_ready_nxt;
  logic            r_atm_rst;
  logic            r_res_valid;
  logic            r_busy;
  logic            r_in_ready;
  logic [31:0]     r_res_balance;
  logic            r_res_success;
  logic [3:0]      r_res_acc_num;
  logic [7:0]      r_seq;

  assign w_entry = {in_acc_num, in_operation, in_pin, in_new_pin, in_amount, in_language};
  assign w_push  = in_valid && r_in_ready;
  assign w_pop   = (r_state == S_IDLE) && (r_count != CW'(0));

  // FIFO storage and pointers; a popped entry lands straight in the command register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {EW{1'b0}};
      end
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
      r_cmd    <= {EW{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_entry;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_cmd    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Occupancy update for simultaneous push/pop
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_state_nxt = S_RESTART;
        else       w_state_nxt = S_IDLE;
      end
      S_RESTART: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) w_state_nxt = S_CAPTURE;
        else                         w_state_nxt = S_HOLD;
      end
      S_CAPTURE: w_state_nxt = S_REPORT;
      S_REPORT: begin
        if (r_res_valid && res_ready) w_state_nxt = S_IDLE;
        else                          w_state_nxt = S_REPORT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode, expressed as next values of the registered outputs
  always_comb begin
    w_capture      = (r_state == S_CAPTURE);
    w_done         = (r_state == S_REPORT) && r_res_valid && res_ready;
    w_atm_rst_nxt  = (w_state_nxt != S_RESTART);
    w_busy_nxt     = (w_state_nxt != S_IDLE) || (w_count_nxt != CW'(0));
    w_in_ready_nxt = (w_count_nxt != CW'(DEPTH));
    if (r_state == S_HOLD) w_hold_cnt_nxt = r_hold_cnt + HW'(1);
    else                   w_hold_cnt_nxt = {HW{1'b0}};
    if (w_capture)   w_res_valid_nxt = 1'b1;
    else if (w_done) w_res_valid_nxt = 1'b0;
    else             w_res_valid_nxt = r_res_valid;
  end

  // Registered control outputs, hold counter, result capture and sequence number
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_atm_rst     <= 1'b0;
      r_res_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_in_ready    <= 1'b1;
      r_hold_cnt    <= {HW{1'b0}};
      r_res_balance <= 32'd0;
      r_res_success <= 1'b0;
      r_res_acc_num <= 4'd0;
      r_seq         <= 8'd0;
    end else begin
      r_atm_rst   <= w_atm_rst_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
      if (w_capture) begin
        r_res_balance <= atm_balance;
        r_res_success <= atm_success;
        r_res_acc_num <= r_cmd[51:48];
      end
      if (w_done) begin
        r_seq <= r_seq + 8'd1;
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign atm_rst       = r_atm_rst;
  assign atm_acc_num   = r_cmd[51:48];
  assign atm_operation = r_cmd[47:45];
  assign atm_pin       = r_cmd[44:31];
  assign atm_new_pin   = r_cmd[30:17];
  assign atm_amount    = r_cmd[16:1];
  assign atm_language  = r_cmd[0];
  assign res_valid     = r_res_valid;
  assign res_balance   = r_res_balance;
  assign res_success   = r_res_success;
  assign res_acc_num   = r_res_acc_num;
  assign res_seq       = r_seq;
  assign busy          = r_busy;

endmodule
